run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl.sv | 135 +++++++++++++
 tb/tb_run_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: run sequencer for a small core.
// Holds core in reset, runs it, stops on done PC or watchdog.
module run_ctrl #(
  parameter int D          = 12,
  parameter int DONE_PC    = 128,
  parameter int CLR_CYCLES = 4,
  parameter int CW         = 16,
  parameter int TIMEOUT    = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [D-1:0]  prog_ctr,
  output logic          core_rst,
  output logic          run_en,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [3:0] CLR_LOAD =
    4'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT - 1);
  localparam logic [D-1:0] PC_END =
    D'(DONE_PC);

  state_t        state;
  state_t        state_nx;
  logic [3:0]    clr_cnt;
  logic [3:0]    clr_nx;
  logic [CW-1:0] cnt_nx;

  logic pc_hit;
  logic wd_hit;

  assign pc_hit = (prog_ctr == PC_END);
  assign wd_hit = (cycle_cnt == CNT_LAST);

  // State, clear counter and run-cycle counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nx;
      clr_cnt   <= clr_nx;
      cycle_cnt <= cnt_nx;
    end
  end

  // Next-state logic with abort > done > watchdog priority in RUN
  always_comb begin
    state_nx = state;
    clr_nx   = clr_cnt;
    cnt_nx   = cycle_cnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nx = CLEAR;
          clr_nx   = CLR_LOAD;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt == 4'd0) begin
          state_nx = RUN;
        end else begin
          clr_nx = clr_cnt - 4'd1;
        end
      end
      RUN: begin
        cnt_nx = cycle_cnt + 1'b1;
        if (!req) begin
          state_nx = IDLE;
        end else if (pc_hit) begin
          state_nx = DONE;
        end else if (wd_hit) begin
          state_nx = ERR;
        end
      end
      DONE, ERR: begin
        if (!req) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Moore output decode from the state register only
  always_comb begin
    core_rst = 1'b0;
    run_en   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;
    unique case (state)
      IDLE: begin
        core_rst = 1'b1;
      end
      CLEAR: begin
        core_rst = 1'b1;
        busy     = 1'b1;
      end
      RUN: begin
        run_en = 1'b1;
        busy   = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      ERR: begin
        done    = 1'b1;
        timeout = 1'b1;
      end
      default: begin
        core_rst = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed bench for run_ctrl.
// Outputs packed as {core_rst,run_en,busy,done,timeout}.
module tb_run_ctrl;

  localparam int D  = 12;
  localparam int CW = 16;

  localparam logic [4:0] O_IDLE = 5'b10000;
  localparam logic [4:0] O_CLR  = 5'b10100;
  localparam logic [4:0] O_RUN  = 5'b01100;
  localparam logic [4:0] O_DONE = 5'b00010;
  localparam logic [4:0] O_ERR  = 5'b00011;

  logic          clk;
  logic          reset;
  logic          req;
  logic [D-1:0]  prog_ctr;
  logic          core_rst;
  logic          run_en;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_cnt;

  int n_cmp;
  int n_bad;

  run_ctrl #(
    .D(D),
    .DONE_PC(128),
    .CLR_CYCLES(4),
    .CW(CW),
    .TIMEOUT(200)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .prog_ctr(prog_ctr),
    .core_rst(core_rst),
    .run_en(run_en),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {core_rst, run_en, busy, done, timeout};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enter CLEAR from IDLE and walk its four cycles.
  task automatic do_clear(input logic pc_hit);
    req = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (pc_hit) prog_ctr = 12'd128;
      chk("clr_out", 32'(outs()), 32'(O_CLR));
      chk("clr_cnt", 32'(cycle_cnt), 32'd0);
      tick();
    end
    prog_ctr = '0;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    reset    = 1'b0;
    req      = 1'b0;
    prog_ctr = '0;
    #2;
    chk("rst_out", 32'(outs()), 32'(O_IDLE));
    chk("rst_cnt", 32'(cycle_cnt), 32'd0);
    tick();
    reset = 1'b1;

    // idle after reset
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_out", 32'(outs()), 32'(O_IDLE));
      chk("idle_cnt", 32'(cycle_cnt), 32'd0);
    end

    // normal run, done PC in RUN cycle 50
    do_clear(1'b0);
    for (int i = 1; i <= 50; i++) begin
      chk("run_out", 32'(outs()), 32'(O_RUN));
      chk("run_cnt", 32'(cycle_cnt), 32'(i - 1));
      if (i == 50) prog_ctr = 12'd128;
      tick();
    end
    prog_ctr = '0;
    chk("done_out", 32'(outs()), 32'(O_DONE));
    chk("done_cnt", 32'(cycle_cnt), 32'd50);
    tick();
    chk("done_hold", 32'(outs()), 32'(O_DONE));
    chk("done_frz", 32'(cycle_cnt), 32'd50);
    req = 1'b0;
    tick();
    chk("done_idle", 32'(outs()), 32'(O_IDLE));
    chk("done_keep", 32'(cycle_cnt), 32'd50);
    tick();

    // watchdog; near-miss PC values must not complete
    do_clear(1'b0);
    for (int i = 1; i <= 200; i++) begin
      prog_ctr = (i % 2 == 0) ? 12'd129 : 12'd127;
      chk("wd_run", 32'(outs()), 32'(O_RUN));
      tick();
    end
    prog_ctr = '0;
    chk("wd_out", 32'(outs()), 32'(O_ERR));
    chk("wd_cnt", 32'(cycle_cnt), 32'd200);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_hold", 32'(outs()), 32'(O_ERR));
      chk("wd_frz", 32'(cycle_cnt), 32'd200);
    end
    req = 1'b0;
    tick();
    chk("wd_idle", 32'(outs()), 32'(O_IDLE));
    tick();

    // done and watchdog on the same edge
    do_clear(1'b0);
    for (int i = 1; i <= 200; i++) begin
      if (i == 200) prog_ctr = 12'd128;
      tick();
    end
    prog_ctr = '0;
    chk("sim_out", 32'(outs()), 32'(O_DONE));
    chk("sim_cnt", 32'(cycle_cnt), 32'd200);

    // req held through DONE must not re-arm
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rearm_hold", 32'(outs()), 32'(O_DONE));
    end
    req = 1'b0;
    tick();
    chk("rearm_idle", 32'(outs()), 32'(O_IDLE));
    chk("rearm_cnt", 32'(cycle_cnt), 32'd200);

    // abort in RUN cycle 30; done PC in CLEAR ignored
    do_clear(1'b1);
    for (int i = 1; i <= 30; i++) begin
      chk("ab_run", 32'(outs()), 32'(O_RUN));
      if (i == 30) req = 1'b0;
      tick();
    end
    chk("ab_out", 32'(outs()), 32'(O_IDLE));
    chk("ab_cnt", 32'(cycle_cnt), 32'd30);
    tick();
    chk("ab_stay", 32'(outs()), 32'(O_IDLE));

    // async reset between edges mid-RUN
    do_clear(1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("ar_pre", 32'(outs()), 32'(O_RUN));
    #2;
    reset = 1'b0;
    #1;
    chk("ar_out", 32'(outs()), 32'(O_IDLE));
    chk("ar_cnt", 32'(cycle_cnt), 32'd0);
    req = 1'b0;
    tick();
    #3;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_idle", 32'(outs()), 32'(O_IDLE));
    end

    // req high at first edge after release
    reset = 1'b0;
    #2;
    req   = 1'b1;
    reset = 1'b1;
    tick();
    chk("ar_start", 32'(outs()), 32'(O_CLR));
    req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
